qru_div32: RTL
==============

# qru_div32

Iterative integer divider (quotient and remainder unit, QRU) for the RV32M DIV, DIVU, REM and REMU instructions. It sits in the integer functional unit beside the ALU and MU, reads the same rs1 and rs2 register values, and feeds the result mux that drives register write-back. It is a multi-cycle radix-2 restoring divider with a start/busy/done handshake, so control logic stalls the PC and suppresses `regwe` until `done`.

## Interface

**Parameters**
- `W`, default 32: operand and result width. Latency scales with `W`.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: request a division. Sampled only in IDLE.
- `qructl`, in, 2: operation select, equal to func3[1:0]. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `a`, in, W: dividend (rs1).
- `b`, in, W: divisor (rs2).
- `divres`, out, W: result (quotient or remainder). Registered, and held until the next completion or reset.
- `busy`, out, 1: high while an operation is in flight.
- `done`, out, 1: one-cycle pulse marking `divres` as newly valid.

## Operation

**States:** IDLE, CALC, FIX.

**IDLE, with `start`=1 at an edge:**
- Capture `qructl`, the sign of `a` and the sign of `b` (signed ops only).
- Capture `|a|` and `|b|` as W-bit unsigned values (unsigned ops use `a` and `b` raw).
- Clear the partial remainder and load the iteration counter with W.
- If `b`==0, go to FIX with the special result preloaded. Otherwise go to CALC.

**CALC, one quotient bit per cycle:**
- Shift {rem, quo} left by 1.
- Trial subtract: rem − divisor, computed W+1 bits wide.
- If the result is non-negative, commit it and set quo[0]=1. Otherwise restore and set quo[0]=0.
- Decrement the counter. On the edge where the counter reaches 0, go to FIX.

**FIX, one cycle:**
- Select the quotient (qructl[1]=0) or the remainder (qructl[1]=1).
- Signed ops: negate the quotient if sign(a) XOR sign(b); negate the remainder if sign(a).
- Load `divres`, pulse `done`, return to IDLE.

**Arithmetic rules (RISC-V M spec):**
- Divide by zero:
  - DIV and DIVU give all ones.
  - REM and REMU give `a` unchanged.
  - This bypasses sign fix-up.
- Signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF): DIV gives 0x80000000 and REM gives 0. This falls out of the magnitude path, since |0x80000000| is 0x80000000 unsigned, and it must not trap.
- Remainder sign always follows the dividend. Quotient truncates toward zero.

**Boundary conditions:**
- Operands and `qructl` are captured at start. Changes on `a`, `b` or `qructl` while busy are ignored.
- `start` while busy is ignored. It is neither queued nor allowed to corrupt the in-flight operation.
- `start` in the cycle `done` is high is accepted, since the FSM is already in IDLE. This gives back-to-back operation.
- `rst` asserted at any time forces IDLE immediately, with no clock required: `divres`=0, `busy`=0, `done`=0, counter=0, datapath registers cleared. The aborted operation produces no `done`.

## Timing

- **Reset values:** `divres`=0, `busy`=0, `done`=0, state IDLE.
- **Normal op:**
  - `start` sampled at edge E0.
  - `busy`=1 from after E0 through the cycle before E(W+1).
  - Iterations run at E1 through EW.
  - At E(W+1), `divres` is loaded, `done`=1 and `busy`=0.
  - `done` returns to 0 at E(W+2) unless a new op completes then.
  - Latency is W+1 = 33 cycles.
- **Divide by zero:** at E1, `divres` is loaded, `done`=1 and `busy`=0 (latency 1). `busy` is high only between E0 and E1.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan

1. **Unsigned basics.**
   - DIVU `a`=100, `b`=7 → `divres`=14 with `done` at E33.
   - REMU with the same operands → 2.
   - DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
2. **Signed rounding.**
   - DIV −7/2 → 0xFFFFFFFD.
   - REM −7/2 → 0xFFFFFFFF.
   - DIV 7/−2 → 0xFFFFFFFD.
   - REM 7/−2 → 1.
3. **Divide by zero.**
   - DIV 5/0 → 0xFFFFFFFF with `done` at E1.
   - REM −5/0 → 0xFFFFFFFB.
   - DIVU 0x80000000/0 → 0xFFFFFFFF.
   - REMU 9/0 → 9.
4. **Overflow.**
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000 at E33.
   - REM with the same operands → 0.
5. **Handshake.**
   - Pulse `start` again at E5 and change `a`/`b` mid-op → the first result is unaffected, and exactly one `done` fires at E33.
   - `start` in the `done` cycle → the second result arrives 33 cycles later.
6. **Reset mid-operation.**
   - Assert `rst` between E10 and E11, asynchronously → `busy`, `done` and `divres` go to 0 immediately, and no `done` follows.
   - After release, DIVU 81/9 → 9 at E33.

Source files
------------

// File: rtl/qru_div32.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle, result after W+1 cycles.
// Divide-by-zero skips the iteration loop and completes one cycle after start.
module qru_div32 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   qructl,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] divres,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic          neg_a_q, neg_a_d;
   logic          neg_b_q, neg_b_d;
   logic          dz_q, dz_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [W-1:0]  res_q, res_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          sgn_op;
   logic [W-1:0]  abs_a, abs_b;
   logic [W:0]    shf, dif;
   logic [W-1:0]  raw_val, fix_val;
   logic          do_neg;

   always_comb begin
      sgn_op  = ~qructl[0];
      abs_a   = (sgn_op && a[W-1]) ? -a : a;
      abs_b   = (sgn_op && b[W-1]) ? -b : b;
      shf     = {rem_q, quo_q[W-1]};
      dif     = shf - {1'b0, dvs_q};
      raw_val = op_q[1] ? rem_q : quo_q;
      // Quotient sign is sign(a)^sign(b); remainder sign follows the dividend.
      do_neg  = ~dz_q & ~op_q[0] & (op_q[1] ? neg_a_q : (neg_a_q ^ neg_b_q));
      fix_val = do_neg ? -raw_val : raw_val;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      dz_d    = dz_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = qructl;
               neg_a_d = sgn_op & a[W-1];
               neg_b_d = sgn_op & b[W-1];
               dvs_d   = abs_b;
               cnt_d   = CW'(W);
               busy_d  = 1'b1;
               if (b == '0) begin
                  // Special result preloaded so FIX only has to select it.
                  dz_d    = 1'b1;
                  quo_d   = '1;
                  rem_d   = a;
                  state_d = S_FIX;
               end else begin
                  dz_d    = 1'b0;
                  quo_d   = abs_a;
                  rem_d   = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            quo_d = {quo_q[W-2:0], ~dif[W]};
            rem_d = dif[W] ? shf[W-1:0] : dif[W-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            res_d   = fix_val;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         dz_q    <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         dz_q    <= dz_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign divres = res_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
